// File: rtl/m_s_pkg.sv
// Shared types and constants for the crossbar slave memory controller.
// Also holds the saturating counter helper used for the access statistics.
package m_s_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 11;
    localparam int CNT_W  = 16;
    localparam int WAIT_W = 4;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Increment by one when enabled, holding at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Word storage: one synchronous write port and one registered read port.
// Contents are intentionally not reset.
module slave_mem_array
    import m_s_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slave_mem_ctrl.sv
// Crossbar slave-port memory controller: request FSM with programmable wait
// states, word storage, and saturating read/write access counters.
module slave_mem_ctrl
    import m_s_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int DEPTH       = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              slave_req,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic              slave_cmd,
    input  logic [DATA_W-1:0] slave_wdata,
    output logic              slave_ack,
    output logic [DATA_W-1:0] slave_rdata,
    output logic              slave_resp,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output state_t            dbg_state
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: the master raises slave_req with addr/cmd/wdata and holds them
    // until slave_ack; the access happens at the edge closing the ACK cycle and
    // a read returns its word with slave_resp in the following cycle.

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic [DATA_W-1:0]  mem_rdata;
    logic               acc_rd;
    logic               acc_wr;
    logic               addr_unused;

    assign acc_rd = (state_q == ACK) && (slave_cmd == CMD_RD);
    assign acc_wr = (state_q == ACK) && (slave_cmd == CMD_WR);

    // Upper address bits alias; they are deliberately dropped here.
    assign addr_unused = ^slave_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (slave_req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ACK;
                        end else begin
                            state_q <= WAIT;
                            wait_q  <= WAIT_W'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (!slave_req) begin
                        state_q <= IDLE;
                    end else if (wait_q == '0) begin
                        state_q <= ACK;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ACK: begin
                    state_q <= (slave_cmd == CMD_RD) ? RESP : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= sat_inc(rd_cnt_q, acc_rd);
            wr_cnt_q <= sat_inc(wr_cnt_q, acc_wr);
        end
    end

    // The array samples address/data at the ACK closing edge; its registered
    // read word is only exposed while the FSM sits in RESP.
    slave_mem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (acc_wr),
        .wr_addr (slave_addr[AW-1:0]),
        .wr_data (slave_wdata),
        .rd_en   (acc_rd),
        .rd_addr (slave_addr[AW-1:0]),
        .rd_data (mem_rdata)
    );

    assign slave_ack   = (state_q == ACK);
    assign slave_resp  = (state_q == RESP);
    assign slave_rdata = (state_q == RESP) ? mem_rdata : '0;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_slave_mem_ctrl.sv
// Directed bench for slave_mem_ctrl: one instance with no wait states and one
// with three, each driven through its own request port.
module tb_slave_mem_ctrl;
    import m_s_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n [2];
    logic              req   [2];
    logic [ADDR_W-1:0] addr  [2];
    logic              cmd   [2];
    logic [DATA_W-1:0] wdata [2];
    logic              ack   [2];
    logic [DATA_W-1:0] rdata [2];
    logic              resp  [2];
    logic [CNT_W-1:0]  rd_cnt[2];
    logic [CNT_W-1:0]  wr_cnt[2];
    state_t            dbg   [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    slave_mem_ctrl #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]), .slave_req(req[0]), .slave_addr(addr[0]),
        .slave_cmd(cmd[0]), .slave_wdata(wdata[0]), .slave_ack(ack[0]),
        .slave_rdata(rdata[0]), .slave_resp(resp[0]), .rd_cnt(rd_cnt[0]),
        .wr_cnt(wr_cnt[0]), .dbg_state(dbg[0])
    );

    slave_mem_ctrl #(.WAIT_CYCLES(3), .DEPTH(256)) u_dut3 (
        .clk(clk), .reset_n(rst_n[1]), .slave_req(req[1]), .slave_addr(addr[1]),
        .slave_cmd(cmd[1]), .slave_wdata(wdata[1]), .slave_ack(ack[1]),
        .slave_rdata(rdata[1]), .slave_resp(resp[1]), .rd_cnt(rd_cnt[1]),
        .wr_cnt(wr_cnt[1]), .dbg_state(dbg[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, entered and left just after a falling edge.
    task automatic xact(input int i, input logic c, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int exp_lat,
                        input logic [DATA_W-1:0] exp_rd);
        int n;
        n = 0;
        req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < 40);
        chk("ack_latency", 32'(n), 32'(exp_lat));
        req[i] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack[i]), 0);
        chk("resp_after_ack", 32'(resp[i]), 32'(c == CMD_RD));
        if (c == CMD_RD) begin
            chk("rdata", 32'(rdata[i]), 32'(exp_rd));
            @(negedge clk);
            chk("resp_one_cycle", 32'(resp[i]), 0);
            chk("rdata_idle_zero", 32'(rdata[i]), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired, simulation stalled");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; addr[i] = '0; cmd[i] = CMD_RD; wdata[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", 32'(ack[i]), 0);
            chk("rst_resp", 32'(resp[i]), 0);
            chk("rst_rdata", 32'(rdata[i]), 0);
            chk("rst_rd_cnt", 32'(rd_cnt[i]), 0);
            chk("rst_wr_cnt", 32'(wr_cnt[i]), 0);
            chk("rst_state", 32'(dbg[i]), 32'(IDLE));
            rst_n[i] = 1'b1;
        end

        // No wait states: write then read back.
        xact(0, CMD_WR, 11'h005, 11'h3A5, 1, 11'h000);
        chk("w0_wr_cnt_1", 32'(wr_cnt[0]), 1);
        xact(0, CMD_RD, 11'h005, 11'h000, 1, 11'h3A5);
        chk("w0_rd_cnt_1", 32'(rd_cnt[0]), 1);
        chk("w0_wr_cnt_still_1", 32'(wr_cnt[0]), 1);

        // Back-to-back reads with req kept high through RESP.
        xact(0, CMD_WR, 11'h001, 11'h111, 1, 11'h000);
        xact(0, CMD_WR, 11'h002, 11'h222, 1, 11'h000);
        req[0] = 1'b1; cmd[0] = CMD_RD; addr[0] = 11'h001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[0] && n < 40);
        chk("b2b_first_ack", 32'(n), 1);
        @(negedge clk);
        chk("b2b_first_resp", 32'(resp[0]), 1);
        chk("b2b_first_rdata", 32'(rdata[0]), 32'h111);
        addr[0] = 11'h002;
        @(negedge clk);
        chk("b2b_second_ack", 32'(ack[0]), 1);
        chk("b2b_resp_low", 32'(resp[0]), 0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("b2b_second_resp", 32'(resp[0]), 1);
        chk("b2b_second_rdata", 32'(rdata[0]), 32'h222);
        @(negedge clk);
        chk("b2b_done", 32'(resp[0]), 0);

        // Address aliasing modulo DEPTH.
        xact(0, CMD_WR, 11'h1FF, 11'h011, 1, 11'h000);
        xact(0, CMD_RD, 11'h0FF, 11'h000, 1, 11'h011);
        chk("w0_wr_cnt_4", 32'(wr_cnt[0]), 4);
        chk("w0_rd_cnt_4", 32'(rd_cnt[0]), 4);

        // Write counter saturation.
        force u_dut0.wr_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u_dut0.wr_cnt_q;
        @(negedge clk);
        chk("sat_preload", 32'(wr_cnt[0]), 32'hFFFE);
        xact(0, CMD_WR, 11'h030, 11'h001, 1, 11'h000);
        chk("sat_wr1", 32'(wr_cnt[0]), 32'hFFFF);
        xact(0, CMD_WR, 11'h031, 11'h002, 1, 11'h000);
        chk("sat_wr2", 32'(wr_cnt[0]), 32'hFFFF);
        xact(0, CMD_WR, 11'h032, 11'h003, 1, 11'h000);
        chk("sat_wr3", 32'(wr_cnt[0]), 32'hFFFF);
        chk("sat_rd_cnt", 32'(rd_cnt[0]), 4);

        // Three wait states.
        xact(1, CMD_WR, 11'h020, 11'h2AA, 4, 11'h000);
        xact(1, CMD_RD, 11'h020, 11'h000, 4, 11'h2AA);
        chk("w3_wr_cnt", 32'(wr_cnt[1]), 1);
        chk("w3_rd_cnt", 32'(rd_cnt[1]), 1);

        // Request withdrawn during WAIT.
        req[1] = 1'b1; cmd[1] = CMD_RD; addr[1] = 11'h020;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", 32'(dbg[1]), 32'(WAIT));
        req[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack[1]), 0);
            chk("abort_no_resp", 32'(resp[1]), 0);
        end
        chk("abort_idle", 32'(dbg[1]), 32'(IDLE));
        chk("abort_rd_cnt", 32'(rd_cnt[1]), 1);
        chk("abort_wr_cnt", 32'(wr_cnt[1]), 1);

        // Reset pulse during RESP.
        req[1] = 1'b1; cmd[1] = CMD_RD; addr[1] = 11'h020;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[1] && n < 40);
        chk("rst_resp_ack_lat", 32'(n), 4);
        req[1] = 1'b0;
        @(negedge clk);
        chk("rst_resp_pre", 32'(resp[1]), 1);
        #1 rst_n[1] = 1'b0;
        #1;
        chk("rst_resp_resp", 32'(resp[1]), 0);
        chk("rst_resp_rdata", 32'(rdata[1]), 0);
        chk("rst_resp_rd_cnt", 32'(rd_cnt[1]), 0);
        chk("rst_resp_state", 32'(dbg[1]), 32'(IDLE));
        @(negedge clk);
        rst_n[1] = 1'b1;

        // Storage survives reset.
        xact(1, CMD_RD, 11'h020, 11'h000, 4, 11'h2AA);
        chk("post_rst_rd_cnt", 32'(rd_cnt[1]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
